// File: rtl/micro_seq_pkg.sv
// -----------------------------------------------------------------------------
// micro_seq_pkg
// Shared definitions for the microprogram sequencer: widths, microstore word
// field positions, sequencing opcodes, FSM state encoding and a helper that
// packs a microstore word from its fields.
// -----------------------------------------------------------------------------
package micro_seq_pkg;

  localparam int MS_W    = 9;
  localparam int UADDR_W = 5;
  localparam int ROM_W   = 18;

  // Microstore word layout: [17:9] microword, [8:7] seq_op,
  // [6:5] flag select, [4:0] branch target.
  localparam int MS_LSB  = 9;
  localparam int OP_LSB  = 7;
  localparam int SEL_LSB = 5;
  localparam int TGT_LSB = 0;

  typedef enum logic [1:0] {
    SEQ_NEXT = 2'b00,
    SEQ_JUMP = 2'b01,
    SEQ_CJMP = 2'b10,
    SEQ_END  = 2'b11
  } seq_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_ISSUE = 2'b10,
    ST_FIN   = 2'b11
  } state_e;

  function automatic logic [ROM_W-1:0] ms_word(
    input logic [MS_W-1:0]    m,
    input seq_op_e            op,
    input logic [1:0]         sel,
    input logic [UADDR_W-1:0] tgt
  );
    return {m, op, sel, tgt};
  endfunction

endpackage

// File: rtl/micro_seq_if.sv
// -----------------------------------------------------------------------------
// micro_seq_if
// Groups the sequencer's control inputs and microword outputs.
//   start, entry_addr[4:0], flags[3:0], stall : requester -> sequencer
//   ms_m[8:0], ms_valid, upc[4:0], busy, done : sequencer -> requester
//   uinst_cnt[15:0] : issued-word counter, present only when
//                     MICRO_SEQ_TRACE_EN is defined
// Modports: master (requester side), slave (sequencer side).
// -----------------------------------------------------------------------------
interface micro_seq_if;
  import micro_seq_pkg::*;

  logic               start;
  logic [UADDR_W-1:0] entry_addr;
  logic [3:0]         flags;
  logic               stall;
  logic [MS_W-1:0]    ms_m;
  logic               ms_valid;
  logic [UADDR_W-1:0] upc;
  logic               busy;
  logic               done;
`ifdef MICRO_SEQ_TRACE_EN
  logic [15:0]        uinst_cnt;
`endif

  modport master (
    output start, entry_addr, flags, stall,
`ifdef MICRO_SEQ_TRACE_EN
    input  uinst_cnt,
`endif
    input  ms_m, ms_valid, upc, busy, done
  );

  modport slave (
    input  start, entry_addr, flags, stall,
`ifdef MICRO_SEQ_TRACE_EN
    output uinst_cnt,
`endif
    output ms_m, ms_valid, upc, busy, done
  );

endinterface

// File: rtl/micro_rom.sv
// -----------------------------------------------------------------------------
// micro_rom
// 32 x 18 microstore with a registered (synchronous) read port. The output
// register only updates when rd_en_i is high, so the word stays put while the
// consumer stalls.
//   clk     : clock
//   rd_en_i : capture the word at addr_i on this edge
//   addr_i  : microstore address
//   data_o  : registered microstore word
// -----------------------------------------------------------------------------
module micro_rom
  import micro_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rd_en_i,
  input  logic [UADDR_W-1:0] addr_i,
  output logic [ROM_W-1:0]   data_o
);

  logic [ROM_W-1:0] word_d;
  logic [ROM_W-1:0] data_q;

  // Default program: 0 -> 1 -> (Z ? 4 : 2) -> 5 (END), unused words are END.
  always_comb begin
    word_d = ms_word(9'b0, SEQ_END, 2'd0, 5'd0);
    case (addr_i)
      5'd0:    word_d = ms_word(9'b000_010_010, SEQ_NEXT, 2'd0, 5'd0);
      5'd1:    word_d = ms_word(9'b001_110_001, SEQ_CJMP, 2'd0, 5'd4);
      5'd2:    word_d = ms_word(9'b010_011_011, SEQ_JUMP, 2'd0, 5'd5);
      5'd4:    word_d = ms_word(9'b011_010_110, SEQ_NEXT, 2'd0, 5'd0);
      5'd5:    word_d = ms_word(9'b111_100_100, SEQ_END,  2'd0, 5'd0);
      default: word_d = ms_word(9'b0, SEQ_END, 2'd0, 5'd0);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rd_en_i) data_q <= word_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/micro_seq.sv
// -----------------------------------------------------------------------------
// micro_seq
// Microprogram sequencer: on start it walks the microstore from entry_addr,
// issuing one microword every two cycles (FETCH then ISSUE) until an END word
// has been issued, then pulses done.
//   clk : clock, rst : asynchronous active-high reset
//   bus : micro_seq_if.slave (start/entry_addr/flags/stall in,
//         ms_m/ms_valid/upc/busy/done out)
// Optional feature: define MICRO_SEQ_TRACE_EN to add bus.uinst_cnt, a
// saturating count of microwords accepted since the last start.
// -----------------------------------------------------------------------------
module micro_seq
  import micro_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  micro_seq_if.slave bus
);

  state_e             state_q, state_d;
  logic [UADDR_W-1:0] upc_q, upc_d;
  logic               rom_en;
  logic               issue_exit;
  logic [ROM_W-1:0]   rom_data;

  seq_op_e            seq_op;
  logic [1:0]         flag_sel;
  logic [UADDR_W-1:0] target;

  micro_rom u_rom (
    .clk     (clk),
    .rd_en_i (rom_en),
    .addr_i  (upc_q),
    .data_o  (rom_data)
  );

  assign seq_op   = seq_op_e'(rom_data[OP_LSB +: 2]);
  assign flag_sel = rom_data[SEL_LSB +: 2];
  assign target   = rom_data[TGT_LSB +: UADDR_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      upc_q   <= '0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
    end
  end

  // Next-state and next-upc; the ROM is only read in FETCH so its output
  // register keeps the issued word stable across stall cycles.
  always_comb begin
    state_d    = state_q;
    upc_d      = upc_q;
    rom_en     = 1'b0;
    issue_exit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FETCH;
          upc_d   = bus.entry_addr;
        end
      end
      ST_FETCH: begin
        rom_en  = 1'b1;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!bus.stall) begin
          issue_exit = 1'b1;
          state_d    = ST_FETCH;
          case (seq_op)
            SEQ_NEXT: upc_d = upc_q + 5'd1;
            SEQ_JUMP: upc_d = target;
            SEQ_CJMP: upc_d = bus.flags[flag_sel] ? target : upc_q + 5'd1;
            SEQ_END:  state_d = ST_FIN;
            default:  upc_d = upc_q;
          endcase
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode straight from the state register, so an asynchronous
  // reset clears them in the same cycle.
  assign bus.ms_valid = (state_q == ST_ISSUE);
  assign bus.ms_m     = (state_q == ST_ISSUE) ? rom_data[MS_LSB +: MS_W] : '0;
  assign bus.upc      = upc_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_FIN);

`ifdef MICRO_SEQ_TRACE_EN
  logic [15:0] uinst_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uinst_cnt_q <= '0;
    end else if (state_q == ST_IDLE && bus.start) begin
      uinst_cnt_q <= '0;
    end else if (issue_exit && uinst_cnt_q != 16'hFFFF) begin
      uinst_cnt_q <= uinst_cnt_q + 16'd1;
    end
  end

  assign bus.uinst_cnt = uinst_cnt_q;
`endif

endmodule
